// File: rtl/f2c_producer_pkg.sv
// f2c_producer_pkg
//   Shared types for the CPU-fed F2C stream source.
//   Data    : one 32-bit CPU register write
//   uint64  : one stream word
//   F2cState: pairing state (EMPTY_HALF = no LSW held since last push,
//             LSW_HELD = an LSW is waiting for its MSW)
//   swapHalves(): 16-bit half swap used for the optional endian fix-up.
package f2c_producer_pkg;

    typedef logic [31:0] Data;
    typedef logic [63:0] uint64;

    typedef enum logic {
        EMPTY_HALF = 1'b0,
        LSW_HELD   = 1'b1
    } F2cState;

    function automatic Data swapHalves(input Data d);
        return {d[15:0], d[31:16]};
    endfunction

endpackage

// File: rtl/f2c_fifo.sv
// f2c_fifo
//   Single-clock show-ahead FIFO with a registered output word.
//   A word pushed at edge N is presented on popData/popValid after edge N+1.
//   Ports:
//     clk, reset_n        clock, async active-low reset
//     flush               sync clear of pointers and output valid
//     push, pushData      write request (refused when full or flushing)
//     popReady            consumer ready; pop = popValid & popReady
//     popData, popValid   registered head-of-queue word
//     full                all 2**DEPTH_LOG2 entries occupied
//     level               words held, including the one on popData
module f2c_fifo #(
    parameter int WIDTH      = 64,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  push,
    input  logic [WIDTH-1:0]      pushData,
    input  logic                  popReady,
    output logic [WIDTH-1:0]      popData,
    output logic                  popValid,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] PTR_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_LOG2:0] wrPtr;
    logic [DEPTH_LOG2:0] rdPtr;
    logic [DEPTH_LOG2:0] rdNext;
    logic                pushOk;
    logic                pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full   = (wrPtr[DEPTH_LOG2] != rdPtr[DEPTH_LOG2]) &&
                    (wrPtr[DEPTH_LOG2-1:0] == rdPtr[DEPTH_LOG2-1:0]);
    assign level  = wrPtr - rdPtr;
    assign pop    = popValid & popReady;
    assign pushOk = push & ~full & ~flush;
    assign rdNext = pop ? (rdPtr + PTR_ONE) : rdPtr;

    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtr[DEPTH_LOG2-1:0]] <= pushData;
        end
    end

    // Output stage: prefetch the head selected by the post-pop read pointer.
    // Comparing against the pre-push write pointer gives the one-cycle
    // push-to-visible latency; an unpopped head is simply reloaded unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            popValid <= 1'b0;
            popData  <= '0;
        end else if (flush) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            popValid <= 1'b0;
        end else begin
            if (pushOk) begin
                wrPtr <= wrPtr + PTR_ONE;
            end
            rdPtr    <= rdNext;
            popValid <= (wrPtr != rdNext);
            popData  <= mem[rdNext[DEPTH_LOG2-1:0]];
        end
    end

endmodule

// File: rtl/f2c_producer.sv
// f2c_producer
//   CPU-fed source for the FPGA->CPU DMA stream. CPU writes arrive as 32-bit
//   halves (LSW then MSW); they are paired into 64-bit words, queued in
//   f2c_fifo and offered on a valid/ready stream toward tlp_xcvr.
//   Optional feature: define F2C_CKSUM_EN to add cksum_out, the modulo-2**64
//   sum of every popped word.
//   Ports:
//     pcieClk_in, reset_n_in   clock, async active-low reset
//     f2cReset_in              sync flush (pointers, FSM, hold, overflow, checksum)
//     wrLsw_in, wrMsw_in       CPU write strobes for the LSW / MSW channels
//     wrData_in                CPU write data
//     wrReady_out              an MSW write can be accepted (FIFO not full)
//     f2cData_out/f2cValid_out/f2cReady_in   output stream
//     level_out                words currently queued
//     overflow_out             sticky: an MSW arrived while full and was dropped
//     cksum_out                (F2C_CKSUM_EN only) sum of popped words
module f2c_producer
    import f2c_producer_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int EN_SWAP    = 0
) (
    input  logic                pcieClk_in,
    input  logic                reset_n_in,
    input  logic                f2cReset_in,
    input  logic                wrLsw_in,
    input  logic                wrMsw_in,
    input  Data                 wrData_in,
    output logic                wrReady_out,
    output uint64               f2cData_out,
    output logic                f2cValid_out,
    input  logic                f2cReady_in,
    output logic [DEPTH_LOG2:0] level_out,
`ifdef F2C_CKSUM_EN
    output uint64               cksum_out,
`endif
    output logic                overflow_out
);

    F2cState state;
    Data     hold;
    Data     wrDataSw;
    uint64   pushWord;
    logic    full;

    assign wrDataSw    = (EN_SWAP != 0) ? swapHalves(wrData_in) : wrData_in;
    // A simultaneous LSW supplies the low half directly instead of the hold reg.
    assign pushWord    = {wrDataSw, (wrLsw_in ? wrDataSw : hold)};
    assign wrReady_out = ~full;

    f2c_fifo #(
        .WIDTH      (64),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) fifo (
        .clk      (pcieClk_in),
        .reset_n  (reset_n_in),
        .flush    (f2cReset_in),
        .push     (wrMsw_in),
        .pushData (pushWord),
        .popReady (f2cReady_in),
        .popData  (f2cData_out),
        .popValid (f2cValid_out),
        .full     (full),
        .level    (level_out)
    );

    // Pairing FSM; hold is not cleared after a push so a bare MSW reuses it.
    always_ff @(posedge pcieClk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state        <= EMPTY_HALF;
            hold         <= '0;
            overflow_out <= 1'b0;
        end else if (f2cReset_in) begin
            state        <= EMPTY_HALF;
            hold         <= '0;
            overflow_out <= 1'b0;
        end else begin
            if (wrMsw_in && full) begin
                overflow_out <= 1'b1;
            end
            if (wrLsw_in) begin
                hold <= wrDataSw;
            end
            case (state)
                EMPTY_HALF: begin
                    if (!wrMsw_in && wrLsw_in) begin
                        state <= LSW_HELD;
                    end
                end
                LSW_HELD: begin
                    if (wrMsw_in) begin
                        state <= EMPTY_HALF;
                    end
                end
                default: state <= EMPTY_HALF;
            endcase
        end
    end

`ifdef F2C_CKSUM_EN
    always_ff @(posedge pcieClk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cksum_out <= '0;
        end else if (f2cReset_in) begin
            cksum_out <= '0;
        end else if (f2cValid_out && f2cReady_in) begin
            cksum_out <= cksum_out + f2cData_out;
        end
    end
`endif

endmodule

// File: tb/tb_f2c_producer.sv
`timescale 1ns/1ps
module tb_f2c_producer;

    localparam int DL2   = 5;
    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    always #4 clk = ~clk;

    logic        rstN, flush, lsw, msw, rdy;
    logic [31:0] wd;
    logic        wrReady, vOut, ovf;
    logic [63:0] dOut;
    logic [5:0]  lvl;
    logic        sWrReady, sVOut, sOvf;
    logic [63:0] sDOut;
    logic [5:0]  sLvl;
`ifdef F2C_CKSUM_EN
    logic [63:0] cks, sCks;
`endif

    f2c_producer #(.DEPTH_LOG2(DL2), .EN_SWAP(0)) dut (
        .pcieClk_in(clk), .reset_n_in(rstN), .f2cReset_in(flush),
        .wrLsw_in(lsw), .wrMsw_in(msw), .wrData_in(wd), .wrReady_out(wrReady),
        .f2cData_out(dOut), .f2cValid_out(vOut), .f2cReady_in(rdy),
        .level_out(lvl),
`ifdef F2C_CKSUM_EN
        .cksum_out(cks),
`endif
        .overflow_out(ovf));

    f2c_producer #(.DEPTH_LOG2(DL2), .EN_SWAP(1)) dutSwap (
        .pcieClk_in(clk), .reset_n_in(rstN), .f2cReset_in(flush),
        .wrLsw_in(lsw), .wrMsw_in(msw), .wrData_in(wd), .wrReady_out(sWrReady),
        .f2cData_out(sDOut), .f2cValid_out(sVOut), .f2cReady_in(rdy),
        .level_out(sLvl),
`ifdef F2C_CKSUM_EN
        .cksum_out(sCks),
`endif
        .overflow_out(sOvf));

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a plain queue of queued words plus visible-head state.
    logic [63:0] q[$];
    logic [31:0] mHold;
    bit          mValid, mOvf;
    logic [63:0] mData, mCks;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        q.delete();
        mHold = '0; mValid = 0; mOvf = 0; mData = '0; mCks = '0;
    endtask

    task automatic modelStep(input bit l, input bit m, input logic [31:0] d, input bit r, input bit f);
        bit fullPre;
        fullPre = (q.size() == DEPTH);
        if (f) begin
            q.delete(); mValid = 0; mHold = '0; mOvf = 0; mCks = '0;
        end else begin
            if (mValid && r) begin
                mCks = mCks + q[0];
                void'(q.pop_front());
            end
            // A word pushed at this edge is not visible until the next one.
            mValid = (q.size() > 0);
            if (mValid) mData = q[0];
            if (m) begin
                if (fullPre) mOvf = 1;
                else q.push_back({d, (l ? d : mHold)});
            end
            if (l) mHold = d;
        end
    endtask

    task automatic compareModel();
        check("valid", 64'(vOut), 64'(mValid));
        if (mValid) check("data", dOut, mData);
        check("level", 64'(lvl), 64'(q.size()));
        check("overflow", 64'(ovf), 64'(mOvf));
        check("wrReady", 64'(wrReady), 64'(q.size() < DEPTH));
`ifdef F2C_CKSUM_EN
        check("cksum", cks, mCks);
`endif
    endtask

    task automatic cycle(input bit l, input bit m, input logic [31:0] d, input bit r, input bit f);
        lsw = l; msw = m; wd = d; rdy = r; flush = f;
        @(posedge clk);
        modelStep(l, m, d, r, f);
        @(negedge clk);
        compareModel();
        lsw = 0; msw = 0; flush = 0;
    endtask

    typedef struct {
        bit          l, m;
        logic [31:0] d;
        bit          r;
        bit          eV;
        logic [63:0] eD;
        int          eL;
    } vec_t;

    vec_t        tbl[4];
    logic [63:0] got[$];
    logic [31:0] iv;

    initial begin
        rstN = 1; flush = 0; lsw = 0; msw = 0; rdy = 0; wd = '0;
        modelReset();
        #1 rstN = 0;
        #2;
        check("rst_valid", 64'(vOut), 64'd0);
        check("rst_data", dOut, 64'd0);
        check("rst_level", 64'(lvl), 64'd0);
        check("rst_overflow", 64'(ovf), 64'd0);
        check("rst_wrReady", 64'(wrReady), 64'd1);
        @(negedge clk) rstN = 1;

        // Basic pairing and single-cycle pop
        tbl[0] = '{1, 0, 32'h1111_2222, 1, 0, 64'h0, 0};
        tbl[1] = '{0, 1, 32'h3333_4444, 1, 0, 64'h0, 1};
        tbl[2] = '{0, 0, 32'h0,         1, 1, 64'h3333_4444_1111_2222, 1};
        tbl[3] = '{0, 0, 32'h0,         1, 0, 64'h0, 0};
        for (int i = 0; i < 4; i++) begin
            cycle(tbl[i].l, tbl[i].m, tbl[i].d, tbl[i].r, 0);
            check("t1_valid", 64'(vOut), 64'(tbl[i].eV));
            if (tbl[i].eV) check("t1_data", dOut, tbl[i].eD);
            check("t1_level", 64'(lvl), 64'(tbl[i].eL));
        end

        // Fill to full, overflow, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            iv = i;
            cycle(1, 0, iv, 0, 0);
            cycle(0, 1, ~iv, 0, 0);
        end
        check("t2_wrReady_full", 64'(wrReady), 64'd0);
        check("t2_level_full", 64'(lvl), 64'd32);
        cycle(0, 1, 32'hDEAD_BEEF, 0, 0);
        check("t2_overflow", 64'(ovf), 64'd1);
        check("t2_level_after_drop", 64'(lvl), 64'd32);
        got.delete();
        for (int k = 0; k < 40; k++) begin
            if (vOut) got.push_back(dOut);
            cycle(0, 0, 32'h0, 1, 0);
        end
        check("t2_drain_count", 64'(got.size()), 64'd32);
        for (int i = 0; i < DEPTH && i < got.size(); i++) begin
            iv = i;
            check("t2_drain_word", got[i], {~iv, iv});
        end

        // Full with simultaneous pop and MSW write
        cycle(0, 0, 32'h0, 0, 1);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 32'h100 + i, 0, 0);
            cycle(0, 1, 32'h200 + i, 0, 0);
        end
        cycle(0, 1, 32'h5A5A_5A5A, 1, 0);
        check("t3_overflow", 64'(ovf), 64'd1);
        check("t3_level", 64'(lvl), 64'd31);

        // Endian swap instance
        cycle(0, 0, 32'h0, 0, 1);
        cycle(1, 0, 32'hAAAA_BBBB, 0, 0);
        cycle(0, 1, 32'hCCCC_DDDD, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
        check("t4_swap_valid", 64'(sVOut), 64'd1);
        check("t4_swap_data", sDOut, 64'hDDDD_CCCC_BBBB_AAAA);

        // Flush beats a concurrent MSW; hold cleared
        cycle(0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 0, 32'h300 + i, 0, 0);
            cycle(0, 1, 32'h400 + i, 0, 0);
        end
        cycle(1, 0, 32'h5555_5555, 0, 0);
        cycle(0, 1, 32'h7777_7777, 0, 1);
        check("t5_valid", 64'(vOut), 64'd0);
        check("t5_level", 64'(lvl), 64'd0);
        check("t5_overflow", 64'(ovf), 64'd0);
        cycle(0, 1, 32'h1, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
        check("t5_valid2", 64'(vOut), 64'd1);
        check("t5_data", dOut, 64'h0000_0001_0000_0000);

`ifdef F2C_CKSUM_EN
        cycle(0, 0, 32'h0, 0, 1);
        cycle(1, 0, 32'h1, 0, 0);         cycle(0, 1, 32'h0, 0, 0);
        cycle(1, 0, 32'h2, 0, 0);         cycle(0, 1, 32'h0, 0, 0);
        cycle(1, 0, 32'hFFFF_FFFF, 0, 0); cycle(0, 1, 32'hFFFF_FFFF, 0, 0);
        for (int k = 0; k < 6; k++) cycle(0, 0, 32'h0, 1, 0);
        check("t6_cksum", cks, 64'd2);
`endif

        // Randomized traffic against the queue model
        cycle(0, 0, 32'h0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            bit phase;
            phase = ((n / 300) % 2) == 1;
            cycle(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom,
                  bit'(($urandom % 4) < (phase ? 1 : 3)), bit'(($urandom % 250) == 0));
        end

        // Asynchronous reset mid-stream
        cycle(0, 0, 32'h0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, $urandom, 0, 0);
            cycle(0, 1, $urandom, 0, 0);
        end
        cycle(0, 1, $urandom, 0, 0);
        #1 rstN = 0;
        #1;
        check("arst_valid", 64'(vOut), 64'd0);
        check("arst_data", dOut, 64'd0);
        check("arst_level", 64'(lvl), 64'd0);
        check("arst_overflow", 64'(ovf), 64'd0);
        check("arst_wrReady", 64'(wrReady), 64'd1);
`ifdef F2C_CKSUM_EN
        check("arst_cksum", cks, 64'd0);
`endif
        modelReset();
        @(negedge clk) rstN = 1;
        cycle(0, 1, 32'h9, 0, 0);
        cycle(0, 0, 32'h0, 0, 0);
        check("post_rst_data", dOut, 64'h0000_0009_0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
